// File: rtl/simmem_id_queue_bank.sv
// simmem_id_queue_bank: shared-pool per-ID linked-list response queues with round-robin locked release
module simmem_id_queue_bank #(
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned IDWidth       = 2,
    parameter int unsigned TotalCapacity = 16,
    localparam int unsigned NumIds       = 2 ** IDWidth,
    localparam int unsigned PtrWidth     = $clog2(TotalCapacity),
    localparam int unsigned CntWidth     = $clog2(TotalCapacity + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NumIds-1:0]    release_en_i,
    input  logic [IDWidth-1:0]   in_id_i,
    input  logic [DataWidth-1:0] in_data_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic [IDWidth-1:0]   out_id_o,
    output logic [DataWidth-1:0] out_data_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [CntWidth-1:0]  occupancy_o
);

    logic [DataWidth-1:0]     data_q [TotalCapacity];
    logic [DataWidth-1:0]     data_d [TotalCapacity];
    logic [PtrWidth-1:0]      next_q [TotalCapacity];
    logic [PtrWidth-1:0]      next_d [TotalCapacity];
    logic [TotalCapacity-1:0] valid_q, valid_d;
    logic [PtrWidth-1:0]      head_q [NumIds];
    logic [PtrWidth-1:0]      head_d [NumIds];
    logic [PtrWidth-1:0]      tail_q [NumIds];
    logic [PtrWidth-1:0]      tail_d [NumIds];
    logic [CntWidth-1:0]      cnt_q  [NumIds];
    logic [CntWidth-1:0]      cnt_d  [NumIds];
    logic [CntWidth-1:0]      occ_q, occ_d;
    logic [IDWidth-1:0]       rr_q, rr_d, lock_id_q, lock_id_d, rr_id, sel_id;
    logic                     lock_q, lock_d;
    logic [PtrWidth-1:0]      free_idx;
    logic [NumIds-1:0]        eligible;
    logic                     push, pop, out_valid;

    assign in_ready_o  = occ_q < CntWidth'(TotalCapacity);
    assign occupancy_o = occ_q;
    assign out_valid_o = out_valid;
    assign out_id_o    = out_valid ? sel_id : '0;
    assign out_data_o  = out_valid ? data_q[head_q[sel_id]] : '0;

    // Free-entry allocation and round-robin selection; a locked ID bypasses arbitration
    always_comb begin
        free_idx = '0;
        for (int i = TotalCapacity - 1; i >= 0; i--)
            if (!valid_q[i]) free_idx = PtrWidth'(i);
        for (int i = 0; i < NumIds; i++)
            eligible[i] = (cnt_q[i] != '0) && release_en_i[i];
        rr_id = rr_q;
        for (int k = NumIds - 1; k >= 0; k--)
            if (eligible[rr_q + IDWidth'(k)]) rr_id = rr_q + IDWidth'(k);
        sel_id    = lock_q ? lock_id_q : rr_id;
        out_valid = lock_q || (|eligible);
        push      = in_valid_i && in_ready_o;
        pop       = out_valid && out_ready_i;
    end

    // List maintenance: push links the new entry at the tail, pop advances the head
    always_comb begin
        data_d  = data_q;
        next_d  = next_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        cnt_d   = cnt_q;
        if (push) begin
            data_d[free_idx]  = in_data_i;
            valid_d[free_idx] = 1'b1;
        end
        if (pop) valid_d[head_q[sel_id]] = 1'b0;
        for (int i = 0; i < NumIds; i++) begin
            if (pop && sel_id == IDWidth'(i)) head_d[i] = next_q[head_q[i]];
            if (push && in_id_i == IDWidth'(i)) begin
                if (cnt_q[i] == '0 || (pop && sel_id == IDWidth'(i) && cnt_q[i] == CntWidth'(1)))
                    head_d[i] = free_idx;
                else
                    next_d[tail_q[i]] = free_idx;
                tail_d[i] = free_idx;
            end
            cnt_d[i] = cnt_q[i] + CntWidth'(push && in_id_i == IDWidth'(i))
                                - CntWidth'(pop && sel_id == IDWidth'(i));
        end
        occ_d     = occ_q + CntWidth'(push) - CntWidth'(pop);
        rr_d      = pop ? sel_id + IDWidth'(1) : rr_q;
        lock_d    = pop ? 1'b0 : (out_valid ? 1'b1 : lock_q);
        lock_id_d = (out_valid && !out_ready_i) ? sel_id : lock_id_q;
    end

    // State registers; reset discards every entry at once
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q    <= '{default: '0};
            next_q    <= '{default: '0};
            valid_q   <= '0;
            head_q    <= '{default: '0};
            tail_q    <= '{default: '0};
            cnt_q     <= '{default: '0};
            occ_q     <= '0;
            rr_q      <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
        end else begin
            data_q    <= data_d;
            next_q    <= next_d;
            valid_q   <= valid_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            cnt_q     <= cnt_d;
            occ_q     <= occ_d;
            rr_q      <= rr_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
        end
    end

endmodule

// File: tb/tb_simmem_id_queue_bank.sv
// tb_simmem_id_queue_bank: directed tests for the per-ID queue bank
module tb_simmem_id_queue_bank;

    logic        clk_i, rst_ni;
    logic [3:0]  release_en_i;
    logic [1:0]  in_id_i;
    logic [31:0] in_data_i;
    logic        in_valid_i, in_ready_o;
    logic [1:0]  out_id_o;
    logic [31:0] out_data_o;
    logic        out_valid_o, out_ready_i;
    logic [4:0]  occupancy_o;
    int          n_checks = 0;
    int          n_fail = 0;

    simmem_id_queue_bank dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .release_en_i(release_en_i),
        .in_id_i(in_id_i), .in_data_i(in_data_i), .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o), .out_id_o(out_id_o), .out_data_o(out_data_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .occupancy_o(occupancy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [1:0] id, input logic [31:0] d);
        in_valid_i = 1'b1;
        in_id_i    = id;
        in_data_i  = d;
        tick();
        in_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        release_en_i = '0;
        out_ready_i = 1'b0;
        in_valid_i = 1'b0;
        tick();
        tick();
        #2 rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready_o); end
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid_o); end
        n_checks++; if (out_id_o !== 2'd0) begin n_fail++; $display("FAIL reset_out_id got %0d want 0", out_id_o); end
        n_checks++; if (out_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data_o); end
        n_checks++; if (occupancy_o !== 5'd0) begin n_fail++; $display("FAIL reset_occ got %0d want 0", occupancy_o); end
    endtask

    task automatic test_basic_order();
        push(2'd1, 32'hA);
        push(2'd1, 32'hB);
        push(2'd1, 32'hC);
        #1;
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_hold_valid got %b want 0", out_valid_o); end
        n_checks++; if (occupancy_o !== 5'd3) begin n_fail++; $display("FAIL basic_occ3 got %0d want 3", occupancy_o); end
        release_en_i = 4'b0010;
        out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (out_valid_o !== 1'b1 || out_id_o !== 2'd1) begin n_fail++; $display("FAIL basic_id[%0d] got v=%b id=%0d want v=1 id=1", i, out_valid_o, out_id_o); end
            n_checks++; if (out_data_o !== 32'hA + 32'(i)) begin n_fail++; $display("FAIL basic_data[%0d] got %h want %h", i, out_data_o, 32'hA + 32'(i)); end
            tick();
        end
        release_en_i = '0;
        out_ready_i = 1'b0;
        #1;
        n_checks++; if (occupancy_o !== 5'd0) begin n_fail++; $display("FAIL basic_occ0 got %0d want 0", occupancy_o); end
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_empty_valid got %b want 0", out_valid_o); end
    endtask

    task automatic test_full();
        logic [31:0] want;
        for (int i = 0; i < 16; i++) begin
            n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL full_ready_before[%0d] got %b want 1", i, in_ready_o); end
            push(2'(i), 32'h100 + 32'(i));
        end
        #1;
        n_checks++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b want 0", in_ready_o); end
        n_checks++; if (occupancy_o !== 5'd16) begin n_fail++; $display("FAIL full_occ got %0d want 16", occupancy_o); end
        push(2'd3, 32'hDEAD);
        #1;
        n_checks++; if (occupancy_o !== 5'd16) begin n_fail++; $display("FAIL full_blocked_occ got %0d want 16", occupancy_o); end
        release_en_i = 4'b0001;
        out_ready_i = 1'b1;
        #1;
        n_checks++; if (out_id_o !== 2'd0 || out_data_o !== 32'h100) begin n_fail++; $display("FAIL full_pop got id=%0d d=%h want id=0 d=100", out_id_o, out_data_o); end
        tick();
        release_en_i = '0;
        out_ready_i = 1'b0;
        #1;
        n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL full_ready_after_pop got %b want 1", in_ready_o); end
        n_checks++; if (occupancy_o !== 5'd15) begin n_fail++; $display("FAIL full_occ15 got %0d want 15", occupancy_o); end
        push(2'd2, 32'h200);
        #1;
        n_checks++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_refill_ready got %b want 0", in_ready_o); end
        release_en_i = 4'b0100;
        out_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            want = (i < 4) ? 32'h102 + 32'(4 * i) : 32'h200;
            #1;
            n_checks++; if (out_id_o !== 2'd2 || out_data_o !== want) begin n_fail++; $display("FAIL full_id2[%0d] got id=%0d d=%h want id=2 d=%h", i, out_id_o, out_data_o, want); end
            tick();
        end
        release_en_i = 4'hF;
        repeat (11) tick();
        release_en_i = '0;
        out_ready_i = 1'b0;
        #1;
        n_checks++; if (occupancy_o !== 5'd0) begin n_fail++; $display("FAIL full_drain_occ got %0d want 0", occupancy_o); end
    endtask

    task automatic test_round_robin();
        logic [1:0]  ids [6] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
        logic [31:0] dat [6] = '{32'h10, 32'h20, 32'h30, 32'h11, 32'h21, 32'h31};
        do_reset();
        push(2'd0, 32'h10); push(2'd0, 32'h11);
        push(2'd1, 32'h20); push(2'd1, 32'h21);
        push(2'd3, 32'h30); push(2'd3, 32'h31);
        release_en_i = 4'hF;
        out_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_checks++; if (out_valid_o !== 1'b1 || out_id_o !== ids[i] || out_data_o !== dat[i]) begin n_fail++; $display("FAIL rr[%0d] got v=%b id=%0d d=%h want id=%0d d=%h", i, out_valid_o, out_id_o, out_data_o, ids[i], dat[i]); end
            tick();
        end
        release_en_i = '0;
        out_ready_i = 1'b0;
        #1;
        n_checks++; if (occupancy_o !== 5'd0) begin n_fail++; $display("FAIL rr_occ got %0d want 0", occupancy_o); end
    endtask

    task automatic test_lock();
        push(2'd2, 32'h77);
        push(2'd2, 32'h78);
        release_en_i = 4'b0100;
        out_ready_i = 1'b0;
        #1;
        n_checks++; if (out_valid_o !== 1'b1 || out_id_o !== 2'd2 || out_data_o !== 32'h77) begin n_fail++; $display("FAIL lock_present got v=%b id=%0d d=%h want v=1 id=2 d=77", out_valid_o, out_id_o, out_data_o); end
        tick();
        release_en_i = '0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (out_valid_o !== 1'b1 || out_id_o !== 2'd2 || out_data_o !== 32'h77) begin n_fail++; $display("FAIL lock_hold[%0d] got v=%b id=%0d d=%h want v=1 id=2 d=77", i, out_valid_o, out_id_o, out_data_o); end
            tick();
        end
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        #1;
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL lock_release_valid got %b want 0", out_valid_o); end
        n_checks++; if (occupancy_o !== 5'd1) begin n_fail++; $display("FAIL lock_one_pop_occ got %0d want 1", occupancy_o); end
        release_en_i = 4'b0100;
        out_ready_i = 1'b1;
        #1;
        n_checks++; if (out_data_o !== 32'h78) begin n_fail++; $display("FAIL lock_next got %h want 78", out_data_o); end
        tick();
        release_en_i = '0;
        out_ready_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        push(2'd0, 32'h5);
        release_en_i = 4'b0001;
        out_ready_i = 1'b1;
        in_valid_i = 1'b1;
        in_id_i = 2'd0;
        in_data_i = 32'h6;
        #1;
        n_checks++; if (out_data_o !== 32'h5) begin n_fail++; $display("FAIL b2b_first got %h want 5", out_data_o); end
        tick();
        in_valid_i = 1'b0;
        out_ready_i = 1'b0;
        #1;
        n_checks++; if (out_valid_o !== 1'b1 || out_id_o !== 2'd0 || out_data_o !== 32'h6) begin n_fail++; $display("FAIL b2b_second got v=%b id=%0d d=%h want v=1 id=0 d=6", out_valid_o, out_id_o, out_data_o); end
        n_checks++; if (occupancy_o !== 5'd1) begin n_fail++; $display("FAIL b2b_occ got %0d want 1", occupancy_o); end
        out_ready_i = 1'b1;
        tick();
        release_en_i = '0;
        out_ready_i = 1'b0;
        #1;
        n_checks++; if (occupancy_o !== 5'd0) begin n_fail++; $display("FAIL b2b_drain got %0d want 0", occupancy_o); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) push(2'd3, 32'h50 + 32'(i));
        release_en_i = 4'b1000;
        #1;
        n_checks++; if (out_valid_o !== 1'b1 || occupancy_o !== 5'd5) begin n_fail++; $display("FAIL arst_pre got v=%b occ=%0d want v=1 occ=5", out_valid_o, occupancy_o); end
        #1 rst_ni = 1'b0;
        #1;
        n_checks++; if (out_valid_o !== 1'b0 || out_id_o !== 2'd0 || out_data_o !== 32'h0) begin n_fail++; $display("FAIL arst_out got v=%b id=%0d d=%h want all 0", out_valid_o, out_id_o, out_data_o); end
        n_checks++; if (occupancy_o !== 5'd0 || in_ready_o !== 1'b1) begin n_fail++; $display("FAIL arst_occ got occ=%0d rdy=%b want occ=0 rdy=1", occupancy_o, in_ready_o); end
        release_en_i = '0;
        tick();
        #2 rst_ni = 1'b1;
        tick();
        push(2'd1, 32'h1);
        release_en_i = 4'b0010;
        out_ready_i = 1'b1;
        #1;
        n_checks++; if (out_valid_o !== 1'b1 || out_id_o !== 2'd1 || out_data_o !== 32'h1) begin n_fail++; $display("FAIL arst_first got v=%b id=%0d d=%h want v=1 id=1 d=1", out_valid_o, out_id_o, out_data_o); end
        tick();
        release_en_i = '0;
        out_ready_i = 1'b0;
        #1;
        n_checks++; if (occupancy_o !== 5'd0 || out_valid_o !== 1'b0) begin n_fail++; $display("FAIL arst_after got occ=%0d v=%b want occ=0 v=0", occupancy_o, out_valid_o); end
    endtask

    initial begin
        rst_ni = 1'b0;
        release_en_i = '0;
        in_id_i = '0;
        in_data_i = '0;
        in_valid_i = 1'b0;
        out_ready_i = 1'b0;
        test_reset();
        test_basic_order();
        test_full();
        test_round_robin();
        test_lock();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
